div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Scheduler in front of the iterative 32-cycle divider.
- Collects DIV/REM uops from two issue ports into a small age-tracked buffer and arbitrates the two ports for free slots.
- Dispatches the oldest buffered uop to the divider only when the divider is idle.
- Tracks the one in-flight operation and kills buffered or in-flight work younger than a mispredicted branch.

Parameters:
- DEPTH, 4, number of buffer entries (2..8).
- DATA_W, 80, opaque uop payload width (operands, opcode, tags), passed through unmodified.
- SQN_W, 7, sequence number width; age compares wrap around.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- IN_uopValid  in  2  per-port uop valid
- IN_uopSqN  in  2*SQN_W  per-port sequence number, port i at [i*SQN_W +: SQN_W]
- IN_uopData  in  2*DATA_W  per-port payload
- OUT_uopReady  out  2  per-port accept, combinational
- IN_branchValid  in  1  mispredict flush valid
- IN_branchSqN  in  SQN_W  sqN of mispredicted branch
- IN_divBusy  in  1  divider busy
- IN_divDone  in  1  divider result valid this cycle
- OUT_divValid  out  1  dispatch strobe to divider, registered
- OUT_divSqN  out  SQN_W  dispatched sqN, registered
- OUT_divData  out  DATA_W  dispatched payload, registered
- OUT_count  out  4  occupied entries, registered
- OUT_inflight  out  1  an op is executing in the divider

Behaviour:
- Reset is async, active-high. While asserted, all entries are invalid; OUT_divValid=0, OUT_divSqN=0, OUT_divData=0, OUT_count=0, OUT_inflight=0, rrPtr=0.
- Age rule: "a younger than b" means $signed(a-b) > 0, computed in SQN_W bits, so wrap is handled.
- Flush: a uop is killed when IN_branchValid and uop sqN is younger than IN_branchSqN. An equal sqN survives.
- Enqueue arbitration uses free = DEPTH - OUT_count at start of cycle:
  - free>=2: ready = 2'b11.
  - free==1: the single valid port gets ready. If both ports are valid, port rrPtr gets ready, then rrPtr toggles.
  - free==0: ready = 0.
- Handshake is valid&ready, one beat.
- A uop accepted in a flush cycle that is itself younger than the branch is consumed (ready still asserted) but not written.
- Each accepted uop goes into the lowest-index free entry; port 0 is written first.
- Flush invalidates matching entries at the clock edge.
- Dispatch candidate: the oldest valid, unkilled entry. An entry written this cycle is not eligible.
- Dispatch condition: candidate exists && !OUT_inflight && !IN_divBusy.
- On dispatch, next cycle: OUT_divValid=1 for exactly one cycle with that entry's sqN/data; the entry is freed; OUT_inflight=1. OUT_divSqN/OUT_divData hold their value when not valid.
- Same-cycle flush and dispatch: the candidate is chosen from survivors only, so a killed entry is never dispatched.
- Inflight tracking:
  - Cleared on IN_divDone.
  - Cleared on a flush that kills the inflight sqN; no result is expected in that case.
  - Done and flush in the same cycle: clear once, no error.
- IN_divDone while !OUT_inflight is ignored.
- OUT_count = previous count + enqueued - dispatched - flushed. It is never above DEPTH and never negative.
- Simultaneous enqueue on both ports plus dispatch with free==1: the dispatch frees a slot only for the next cycle, so only one port is accepted.

Optional Feature:
- DIV_BACK2BACK_EN
- Defined: dispatch may also occur in the cycle IN_divDone=1 (OUT_inflight is treated as 0), giving back-to-back divides with no bubble.
- Undefined: at least one idle cycle after IN_divDone before the next OUT_divValid.

Test Plan:
- Single uop, port 0, sqN=5, idle divider: OUT_divValid pulses 1 cycle after accept with sqN=5; OUT_count goes 1 then 0; OUT_inflight=1 until IN_divDone.
- Ports 0 and 1 both valid, sqN 12 and 10, empty buffer: both accepted. With IN_divBusy=0, sqN 10 dispatches first; sqN 12 dispatches only after IN_divDone (plus 1 cycle without DIV_BACK2BACK_EN).
- Buffer holds DEPTH-1 entries, both ports valid, three such cycles: the single free slot is granted in order port0, port1, port0 (rrPtr toggles each time).
- Entries sqN 3, 8, 9 buffered and inflight sqN=2; flush with branchSqN=7: 8 and 9 are dropped, count=1, inflight stays 1, only sqN 3 dispatches later.
- Wrap check: inflight sqN=126 and buffered sqN 1; flush branchSqN=127: sqN 1 (younger across wrap) is killed and sqN 126 survives.
- Async reset asserted mid-operation with 3 entries and inflight: all outputs are 0 immediately without a clock edge; after release, IN_divDone is ignored.

Source files
------------

// File: rtl/div_issue_if.sv
// Two-port DIV/REM uop issue handshake into div_issue_ctrl.
interface div_issue_if #(
    parameter int unsigned SQN_W  = 7,
    parameter int unsigned DATA_W = 80
);
    logic [1:0]          IN_uopValid;
    logic [2*SQN_W-1:0]  IN_uopSqN;
    logic [2*DATA_W-1:0] IN_uopData;
    logic [1:0]          OUT_uopReady;

    modport master (output IN_uopValid, IN_uopSqN, IN_uopData, input OUT_uopReady);
    modport slave  (input IN_uopValid, IN_uopSqN, IN_uopData, output OUT_uopReady);
endinterface

// File: rtl/div_issue_ctrl.sv
// Age-ordered uop buffer and issue control for the iterative divider.
// Optional `DIV_BACK2BACK_EN: allow dispatch in the same cycle as IN_divDone.
module div_issue_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 80,
    parameter int unsigned SQN_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    div_issue_if.slave        uop,
    input  logic              IN_branchValid,
    input  logic [SQN_W-1:0]  IN_branchSqN,
    input  logic              IN_divBusy,
    input  logic              IN_divDone,
    output logic              OUT_divValid,
    output logic [SQN_W-1:0]  OUT_divSqN,
    output logic [DATA_W-1:0] OUT_divData,
    output logic [3:0]        OUT_count,
    output logic              OUT_inflight
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {ST_IDLE, ST_BUSY} infl_state_e;

    infl_state_e       state_q, state_d;
    logic [SQN_W-1:0]  infl_sqn_q, infl_sqn_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [SQN_W-1:0]  sqn_q [DEPTH];
    logic [SQN_W-1:0]  sqn_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [3:0]        count_q, count_d;
    logic              rr_q, rr_d;
    logic              div_valid_q, div_valid_d;
    logic [SQN_W-1:0]  div_sqn_q, div_sqn_d;
    logic [DATA_W-1:0] div_data_q, div_data_d;

    logic [3:0]        free;
    logic [1:0]        ready;
    logic [DEPTH-1:0]  kill;
    logic [DEPTH-1:0]  taken;
    logic              placed;
    logic              cand_found;
    logic [IDX_W-1:0]  cand_idx;
    logic              issue_blocked;
    logic              dispatch;

    // $signed(a-b) > 0 in SQN_W bits: sign bit clear and non-zero.
    function automatic logic younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] diff;
        diff = a - b;
        return !diff[SQN_W-1] && (diff != '0);
    endfunction

    always_comb begin
        free  = 4'(DEPTH) - count_q;
        ready = '0;
        rr_d  = rr_q;
        if (free >= 4'd2) begin
            ready = 2'b11;
        end else if (free == 4'd1) begin
            if (&uop.IN_uopValid) begin
                ready = rr_q ? 2'b10 : 2'b01;
                rr_d  = ~rr_q;
            end else begin
                ready = uop.IN_uopValid;
            end
        end
    end

    assign uop.OUT_uopReady = ready;

    always_comb begin
        kill       = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kill[i] = IN_branchValid && younger(sqn_q[i], IN_branchSqN);
            if (valid_q[i] && !kill[i] &&
                (!cand_found || younger(sqn_q[cand_idx], sqn_q[i]))) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(i);
            end
        end
    end

`ifdef DIV_BACK2BACK_EN
    assign issue_blocked = (state_q == ST_BUSY) && !IN_divDone;
`else
    assign issue_blocked = (state_q == ST_BUSY);
`endif

    assign dispatch = cand_found && !issue_blocked && !IN_divBusy;

    always_comb begin
        valid_d = valid_q & ~kill;
        sqn_d   = sqn_q;
        data_d  = data_q;
        taken   = valid_q;
        placed  = 1'b0;
        if (dispatch) valid_d[cand_idx] = 1'b0;
        // Only slots empty at the start of the cycle are filled, matching the free count.
        for (int unsigned p = 0; p < 2; p++) begin
            placed = 1'b0;
            if (uop.IN_uopValid[p] && ready[p] &&
                !(IN_branchValid && younger(uop.IN_uopSqN[p*SQN_W +: SQN_W], IN_branchSqN))) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (!placed && !taken[i]) begin
                        placed     = 1'b1;
                        taken[i]   = 1'b1;
                        valid_d[i] = 1'b1;
                        sqn_d[i]   = uop.IN_uopSqN[p*SQN_W +: SQN_W];
                        data_d[i]  = uop.IN_uopData[p*DATA_W +: DATA_W];
                    end
                end
            end
        end
        count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) count_d = count_d + 4'(valid_d[i]);
    end

    always_comb begin
        div_valid_d = dispatch;
        div_sqn_d   = div_sqn_q;
        div_data_d  = div_data_q;
        if (dispatch) begin
            div_sqn_d  = sqn_q[cand_idx];
            div_data_d = data_q[cand_idx];
        end
    end

    always_comb begin
        state_d    = state_q;
        infl_sqn_d = infl_sqn_q;
        if (dispatch) begin
            state_d    = ST_BUSY;
            infl_sqn_d = sqn_q[cand_idx];
        end else if (state_q == ST_BUSY &&
                     (IN_divDone || (IN_branchValid && younger(infl_sqn_q, IN_branchSqN)))) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            infl_sqn_q <= '0;
        end else begin
            state_q    <= state_d;
            infl_sqn_q <= infl_sqn_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            count_q     <= '0;
            rr_q        <= 1'b0;
            div_valid_q <= 1'b0;
            div_sqn_q   <= '0;
            div_data_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sqn_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            count_q     <= count_d;
            rr_q        <= rr_d;
            div_valid_q <= div_valid_d;
            div_sqn_q   <= div_sqn_d;
            div_data_q  <= div_data_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sqn_q[i]  <= sqn_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        OUT_divValid = div_valid_q;
        OUT_divSqN   = div_sqn_q;
        OUT_divData  = div_data_q;
        OUT_count    = count_q;
        OUT_inflight = (state_q == ST_BUSY);
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Testbench for div_issue_ctrl: directed cycle table, async reset sequence, random run vs queue model.
module tb_div_issue_ctrl;
`ifdef DIV_BACK2BACK_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif
    localparam int DEPTH = 4;

    logic        clk, rst;
    logic [1:0]  iv;
    logic [6:0]  is0, is1, ibs;
    logic [79:0] id0, id1;
    logic        ibv, ibusy, idone;
    logic        o_dv, o_infl;
    logic [6:0]  o_dsqn;
    logic [79:0] o_ddata;
    logic [3:0]  o_cnt;

    div_issue_if #(.SQN_W(7), .DATA_W(80)) uif ();
    assign uif.IN_uopValid = iv;
    assign uif.IN_uopSqN   = {is1, is0};
    assign uif.IN_uopData  = {id1, id0};

    div_issue_ctrl #(.DEPTH(DEPTH), .DATA_W(80), .SQN_W(7)) dut (
        .clk(clk), .rst(rst), .uop(uif),
        .IN_branchValid(ibv), .IN_branchSqN(ibs),
        .IN_divBusy(ibusy), .IN_divDone(idone),
        .OUT_divValid(o_dv), .OUT_divSqN(o_dsqn), .OUT_divData(o_ddata),
        .OUT_count(o_cnt), .OUT_inflight(o_infl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [79:0] pay(input logic [6:0] s);
        return {s, 9'h1A5, 64'hDEAD_BEEF_0000_0000 | 64'(s)};
    endfunction

    function automatic bit yng(input logic [6:0] a, input logic [6:0] b);
        logic [6:0] d;
        d = a - b;
        return $signed(d) > 0;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [79:0] d0, input logic [79:0] d1, input logic bv,
                         input logic [6:0] bs, input logic busy, input logic done);
        iv = v; is0 = s0; is1 = s1; id0 = d0; id1 = d1;
        ibv = bv; ibs = bs; ibusy = busy; idone = done;
    endtask

    typedef struct {
        logic [1:0] v; logic [6:0] s0, s1; logic bv; logic [6:0] bs; logic busy, done;
        logic [1:0] rdy; logic dv; logic [6:0] dsqn; logic [3:0] cnt; logic infl;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t T(input int v, input int s0, input int s1, input int bv, input int bs,
                               input int busy, input int done, input int rdy, input int dv,
                               input int dsqn, input int cnt, input int infl);
        vec_t r;
        r.v = 2'(v); r.s0 = 7'(s0); r.s1 = 7'(s1); r.bv = 1'(bv); r.bs = 7'(bs);
        r.busy = 1'(busy); r.done = 1'(done); r.rdy = 2'(rdy); r.dv = 1'(dv);
        r.dsqn = 7'(dsqn); r.cnt = 4'(cnt); r.infl = 1'(infl);
        return r;
    endfunction

    // Behavioural reference: buffer contents as an unordered set, oldest chosen by the age rule.
    typedef struct { logic [6:0] sqn; logic [79:0] data; } ent_t;
    ent_t        mq[$];
    bit          m_infl, m_rr, m_dv;
    logic [6:0]  m_isqn, m_dsqn;
    logic [79:0] m_ddata;

    task automatic model_step(output logic [1:0] rdy);
        int   free, best;
        bit   blk, oldest;
        ent_t surv[$];
        ent_t e;
        free = DEPTH - mq.size();
        if (free >= 2) rdy = 2'b11;
        else if (free == 1) begin
            if (iv == 2'b11) begin
                rdy  = m_rr ? 2'b10 : 2'b01;
                m_rr = !m_rr;
            end else rdy = iv;
        end else rdy = 2'b00;
        foreach (mq[i]) if (!(ibv && yng(mq[i].sqn, ibs))) surv.push_back(mq[i]);
        best = -1;
        foreach (surv[i]) begin
            oldest = 1;
            foreach (surv[j]) if (j != i && yng(surv[i].sqn, surv[j].sqn)) oldest = 0;
            if (oldest) best = i;
        end
        blk  = m_infl && !(B == 1 && idone);
        m_dv = 0;
        if (best >= 0 && !blk && !ibusy) begin
            m_dv    = 1;
            m_dsqn  = surv[best].sqn;
            m_ddata = surv[best].data;
            m_infl  = 1;
            m_isqn  = surv[best].sqn;
            surv.delete(best);
        end else if (m_infl && (idone || (ibv && yng(m_isqn, ibs)))) begin
            m_infl = 0;
        end
        if (iv[0] && rdy[0] && !(ibv && yng(is0, ibs))) begin e.sqn = is0; e.data = id0; surv.push_back(e); end
        if (iv[1] && rdy[1] && !(ibv && yng(is1, ibs))) begin e.sqn = is1; e.data = id1; surv.push_back(e); end
        mq = surv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_infl = 0; m_rr = 0; m_dv = 0; m_isqn = '0; m_dsqn = '0; m_ddata = '0;
    endtask

    initial begin
        logic [1:0] er;
        logic [6:0] ctr;
        bit         sw;

        // Directed cycle table, applied from reset. Columns:
        // v, s0, s1, bv, bs, busy, done | ready, divValid, divSqN, count, inflight
        tbl.push_back(T(1,   5,  0, 0,   0, 0, 0,  3, 0,   0, 1, 0));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 0,  3, 1,   5, 0, 1));
        tbl.push_back(T(0,   0,  0, 0,   0, 1, 0,  3, 0,   0, 0, 1));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 1,  3, 0,   0, 0, 0));
        tbl.push_back(T(3,  12, 10, 0,   0, 0, 0,  3, 0,   0, 2, 0));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 0,  3, 1,  10, 1, 1));
        tbl.push_back(T(0,   0,  0, 0,   0, 1, 0,  3, 0,   0, 1, 1));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 1,  3, B,  12, B ? 0 : 1, B));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 0,  3, 1 - B, 12, 0, 1));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 1,  3, 0,   0, 0, 0));
        tbl.push_back(T(3,  20, 21, 0,   0, 1, 0,  3, 0,   0, 2, 0));
        tbl.push_back(T(1,  22,  0, 0,   0, 1, 0,  3, 0,   0, 3, 0));
        tbl.push_back(T(3,  23, 24, 0,   0, 1, 0,  1, 0,   0, 4, 0));
        tbl.push_back(T(3,  40, 41, 0,   0, 0, 0,  0, 1,  20, 3, 1));
        tbl.push_back(T(3,  25, 26, 0,   0, 1, 0,  2, 0,   0, 4, 1));
        tbl.push_back(T(0,   0,  0, 1,  25, 1, 0,  0, 0,   0, 3, 1));
        tbl.push_back(T(3,  27, 28, 0,   0, 1, 0,  1, 0,   0, 4, 1));
        tbl.push_back(T(0,   0,  0, 1,  20, 1, 0,  0, 0,   0, 0, 1));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 1,  3, 0,   0, 0, 0));
        tbl.push_back(T(3,   2,  3, 0,   0, 0, 0,  3, 0,   0, 2, 0));
        tbl.push_back(T(3,   8,  9, 0,   0, 0, 0,  3, 1,   2, 3, 1));
        tbl.push_back(T(0,   0,  0, 1,   7, 1, 0,  0, 0,   0, 1, 1));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 1,  3, B,   3, B ? 0 : 1, B));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 0,  3, 1 - B, 3, 0, 1));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 1,  3, 0,   0, 0, 0));
        tbl.push_back(T(1, 126,  0, 0,   0, 0, 0,  3, 0,   0, 1, 0));
        tbl.push_back(T(1,   1,  0, 0,   0, 0, 0,  3, 1, 126, 1, 1));
        tbl.push_back(T(0,   0,  0, 1, 127, 1, 0,  3, 0,   0, 0, 1));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 1,  3, 0,   0, 0, 0));
        tbl.push_back(T(1,  50,  0, 0,   0, 0, 0,  3, 0,   0, 1, 0));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 0,  3, 1,  50, 0, 1));
        tbl.push_back(T(0,   0,  0, 1,  40, 0, 0,  3, 0,   0, 0, 0));
        tbl.push_back(T(1,  60,  0, 0,   0, 0, 0,  3, 0,   0, 1, 0));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 0,  3, 1,  60, 0, 1));
        tbl.push_back(T(0,   0,  0, 1,  55, 0, 1,  3, 0,   0, 0, 0));
        tbl.push_back(T(1,  70,  0, 0,   0, 1, 0,  3, 0,   0, 1, 0));
        tbl.push_back(T(1,  71,  0, 0,   0, 1, 0,  3, 0,   0, 2, 0));
        tbl.push_back(T(1,  72,  0, 0,   0, 1, 0,  3, 0,   0, 3, 0));
        tbl.push_back(T(3,  73, 74, 0,   0, 0, 0,  2, 1,  70, 3, 1));
        tbl.push_back(T(0,   0,  0, 0,   0, 0, 1,  0, B,  71, B ? 2 : 3, B));
        tbl.push_back(T(0,   0,  0, 1,  69, 1, 0,  B ? 3 : 0, 0, 0, 0, 0));

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("reset_divValid", 128'(o_dv), 128'(0));
        chk("reset_divSqN", 128'(o_dsqn), 128'(0));
        chk("reset_divData", 128'(o_ddata), 128'(0));
        chk("reset_count", 128'(o_cnt), 128'(0));
        chk("reset_inflight", 128'(o_infl), 128'(0));
        chk("reset_ready", 128'(uif.OUT_uopReady), 128'(3));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].s0, tbl[i].s1, pay(tbl[i].s0), pay(tbl[i].s1),
                  tbl[i].bv, tbl[i].bs, tbl[i].busy, tbl[i].done);
            #1;
            chk($sformatf("row%0d_ready", i), 128'(uif.OUT_uopReady), 128'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_divValid", i), 128'(o_dv), 128'(tbl[i].dv));
            chk($sformatf("row%0d_count", i), 128'(o_cnt), 128'(tbl[i].cnt));
            chk($sformatf("row%0d_inflight", i), 128'(o_infl), 128'(tbl[i].infl));
            if (tbl[i].dv) begin
                chk($sformatf("row%0d_divSqN", i), 128'(o_dsqn), 128'(tbl[i].dsqn));
                chk($sformatf("row%0d_divData", i), 128'(o_ddata), 128'(pay(tbl[i].dsqn)));
            end
        end

        // Async reset with three buffered entries and one op in flight.
        @(negedge clk);
        drive(3, 80, 81, pay(80), pay(81), 0, 0, 0, 0);
        @(negedge clk);
        drive(3, 82, 83, pay(82), pay(83), 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_reset_count", 128'(o_cnt), 128'(3));
        chk("pre_reset_inflight", 128'(o_infl), 128'(1));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;
        #1;
        chk("async_divValid", 128'(o_dv), 128'(0));
        chk("async_divSqN", 128'(o_dsqn), 128'(0));
        chk("async_divData", 128'(o_ddata), 128'(0));
        chk("async_count", 128'(o_cnt), 128'(0));
        chk("async_inflight", 128'(o_infl), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        chk("post_reset_done_inflight", 128'(o_infl), 128'(0));
        chk("post_reset_done_divValid", 128'(o_dv), 128'(0));
        chk("post_reset_count", 128'(o_cnt), 128'(0));
        @(negedge clk);
        drive(1, 90, 0, pay(90), 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("post_reset_dispatch_valid", 128'(o_dv), 128'(1));
        chk("post_reset_dispatch_sqn", 128'(o_dsqn), 128'(90));

        // Random traffic; sqNs allocated from a running counter so live entries stay well inside the age window.
        do_reset();
        ctr = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sw = 1'($urandom_range(0, 1));
            drive(2'($urandom_range(0, 3)), ctr + 7'(sw), ctr + 7'(!sw),
                  80'({$urandom, $urandom, $urandom}), 80'({$urandom, $urandom, $urandom}),
                  ($urandom_range(0, 9) == 0), ctr - 7'($urandom_range(0, 8)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
            #1;
            model_step(er);
            chk("rand_ready", 128'(uif.OUT_uopReady), 128'(er));
            if ((iv & er) != 2'b00) ctr = ctr + 7'd2;
            @(posedge clk);
            #1;
            chk("rand_divValid", 128'(o_dv), 128'(m_dv));
            chk("rand_divSqN", 128'(o_dsqn), 128'(m_dsqn));
            chk("rand_divData", 128'(o_ddata), 128'(m_ddata));
            chk("rand_count", 128'(o_cnt), 128'(mq.size()));
            chk("rand_inflight", 128'(o_infl), 128'(m_infl));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
